uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer directly downstream of uart_top. Captures each byte that
//  uart_top presents on data_out/valid_out, together with its parity_ok flag,
//  into a DEPTH-entry first-word-fall-through FIFO, so a slow consumer does not
//  lose characters. Tracks overrun and parity-error statistics for status reads.
// PARAMETERS
//  DEPTH   8  FIFO entries; power of two, >= 2
//  DATA_W  8  character width; matches uart_top data_out
// PORTS
//  clk            in   1                 system clock, rising edge
//  reset          in   1                 asynchronous, active-high; clears all state
//  rx_valid       in   1                 one-cycle strobe from uart_top valid_out
//  rx_data        in   DATA_W            from uart_top data_out; sampled when rx_valid=1
//  rx_parity_ok   in   1                 from uart_top parity_ok; sampled when rx_valid=1
//  drop_bad       in   1                 1: characters with rx_parity_ok=0 are not stored
//  rd_en          in   1                 pop the head entry; ignored while empty
//  clr_status     in   1                 clear overrun and parity_err_cnt
//  rd_data        out  DATA_W            head entry data when !empty, else 0
//  rd_parity_ok   out  1                 head entry parity flag when !empty, else 0
//  empty          out  1                 count==0
//  full           out  1                 count==DEPTH
//  count          out  $clog2(DEPTH+1)   entries held
//  overrun        out  1                 sticky: a character was lost because FIFO was full
//  parity_err_cnt out  8                 saturating count of received characters with parity_ok=0
// BEHAVIOUR
//  - Reset values: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overrun=0,
//    parity_err_cnt=0, rd_data=0, rd_parity_ok=0. Storage array is not cleared;
//    stale entries are never visible. Reset mid-operation discards all contents.
//  - Storage entry = {parity_ok, data}. Pointers are $clog2(DEPTH) bits, wrap
//    naturally DEPTH-1 -> 0.
//  - accept = rx_valid & ~(drop_bad & ~rx_parity_ok).
//  - pop = rd_en & ~empty. Head advances on the clock edge where pop=1.
//  - push = accept & (~full | pop). Write at wr_ptr, wr_ptr++ on that edge.
//  - Latency: a character pushed at edge N is visible on rd_data/empty after edge N
//    (FWFT). rd_data is a combinational read of mem[rd_ptr], gated to 0 when empty.
//  - count: +1 on push-only, -1 on pop-only, unchanged on push+pop or neither.
//  - Full + accept + pop in the same cycle: push and pop both occur, count stays DEPTH,
//    overrun unchanged.
//  - Full + accept, no pop: character discarded, overrun set next edge.
//  - Empty + accept + rd_en: rd_en is ignored (pop=0), push occurs, count becomes 1.
//  - Dropped bad-parity character (drop_bad=1) never sets overrun.
//  - parity_err_cnt increments on every rx_valid with rx_parity_ok=0, independent of
//    drop_bad and of full; holds at 8'hFF.
//  - clr_status clears overrun and parity_err_cnt. When a set/increment event occurs in
//    the same cycle, the event wins: overrun=1, and parity_err_cnt=1.
//  - No state machine beyond pointer/count control. Pushes are never back-pressured
//    upstream, because uart_top has no ready input.
// STRUCTURE
//  - uart_pkg (shared): UART_DATA_W=8; typedef struct packed {logic parity_ok;
//    logic [UART_DATA_W-1:0] data;} uart_rx_entry_t. The package is reused by the
//    tx side.
//  - One sub-module: uart_sat_counter, WIDTH=8, with inc/clr inputs and clr-with-inc
//    giving 1. Used for parity_err_cnt.
//  - FIFO memory and pointers are inline in this module.
// TESTING
//  1 reset=1 for 1 cycle -> empty=1, count=0, rd_data=0, overrun=0, parity_err_cnt=0.
//  2 rx_valid pulse with data 8'h39, parity_ok=1 -> next cycle empty=0, count=1,
//    rd_data=8'h39, rd_parity_ok=1; then rd_en for 1 cycle -> empty=1, rd_data=0.
//  3 Push 8'h00..8'h07 (DEPTH=8) -> full=1. Push 8'hAA -> overrun=1, count=8.
//    Pop all 8 -> data is 00..07 in order, pointers wrap, empty=1.
//  4 full, with rx_valid(8'h55) and rd_en in the same cycle -> count stays 8,
//    overrun stays 0, 8'h55 is the last entry read.
//  5 drop_bad=1, rx_valid(8'h39, parity_ok=0) x3 -> count=0, parity_err_cnt=3.
//    Same with drop_bad=0 -> stored with rd_parity_ok=0. 300 bad characters
//    -> parity_err_cnt=8'hFF.
//  6 clr_status coincident with a bad-parity rx_valid -> parity_err_cnt=1.
//    Assert reset with count=5 -> empty=1 immediately (async), count=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef struct packed {
    logic                   parity_ok;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear that coincides with an
// increment leaves the counter at 1, so no event is lost.
module uart_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= inc ? WIDTH'(1) : '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with a sticky
// overrun flag and a saturating parity-error counter for status reads.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_parity_ok,
  input  logic                       drop_bad,
  input  logic                       rd_en,
  input  logic                       clr_status,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_parity_ok,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overrun,
  output logic [7:0]                 parity_err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  uart_rx_entry_t mem [DEPTH];
  uart_rx_entry_t head;
  uart_rx_entry_t wr_entry;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic accept;
  logic pop;
  logic push;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign accept = rx_valid & ~(drop_bad & ~rx_parity_ok);
  assign pop    = rd_en & ~empty;
  // A full FIFO still takes a character when the head leaves on the same edge.
  assign push   = accept & (~full | pop);

  assign wr_entry.parity_ok = rx_parity_ok;
  assign wr_entry.data      = UART_DATA_W'(rx_data);

  assign head         = mem[rd_ptr];
  assign rd_data      = empty ? '0 : DATA_W'(head.data);
  assign rd_parity_ok = ~empty & head.parity_ok;

  // NOTE: storage is deliberately not reset; the empty gate keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && full && !pop) begin
        overrun <= 1'b1;
      end else if (clr_status) begin
        overrun <= 1'b0;
      end
    end
  end

  uart_sat_counter #(
    .WIDTH(8)
  ) u_parity_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (rx_valid & ~rx_parity_ok),
    .clr  (clr_status),
    .value(parity_err_cnt)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_parity_ok;
  logic              drop_bad;
  logic              rd_en;
  logic              clr_status;
  logic [DATA_W-1:0] rd_data;
  logic              rd_parity_ok;
  logic              empty;
  logic              full;
  logic [3:0]        count;
  logic              overrun;
  logic [7:0]        parity_err_cnt;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_parity_ok  (rx_parity_ok),
    .drop_bad      (drop_bad),
    .rd_en         (rd_en),
    .clr_status    (clr_status),
    .rd_data       (rd_data),
    .rd_parity_ok  (rd_parity_ok),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .overrun       (overrun),
    .parity_err_cnt(parity_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it, away from the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pok);
    rx_valid     = 1'b1;
    rx_data      = d;
    rx_parity_ok = pok;
    cycle();
    rx_valid     = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_parity_ok = 1'b1;
    drop_bad = 1'b0; rd_en = 1'b0; clr_status = 1'b0;

    // 1: reset state
    cycle();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_pok", rd_parity_ok, 0);
    check("rst_overrun", overrun, 0);
    check("rst_pec", parity_err_cnt, 0);
    reset = 1'b0;
    cycle();

    // 2: single character fall-through and pop
    send(8'h39, 1'b1);
    check("one_empty", empty, 0);
    check("one_count", count, 1);
    check("one_data", rd_data, 8'h39);
    check("one_pok", rd_parity_ok, 1);
    pop_one();
    check("one_pop_empty", empty, 1);
    check("one_pop_data", rd_data, 0);

    // 3: fill, overrun, drain in order with pointer wrap
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b1);
    check("fill_full", full, 1);
    check("fill_count", count, 8);
    check("fill_overrun_pre", overrun, 0);
    send(8'hAA, 1'b1);
    check("ovr_flag", overrun, 1);
    check("ovr_count", count, 8);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_%0d", i), rd_data, 32'(i));
      pop_one();
    end
    check("drain_empty", empty, 1);
    check("drain_overrun_sticky", overrun, 1);
    clr_status = 1'b1;
    cycle();
    clr_status = 1'b0;
    check("clr_overrun", overrun, 0);

    // 4: full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i), 1'b1);
    rx_valid = 1'b1; rx_data = 8'h55; rx_parity_ok = 1'b1; rd_en = 1'b1;
    cycle();
    rx_valid = 1'b0; rd_en = 1'b0;
    check("pp_count", count, 8);
    check("pp_full", full, 1);
    check("pp_overrun", overrun, 0);
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("pp_drain_%0d", i), rd_data, 32'h10 + 32'(i));
      pop_one();
    end
    check("pp_last", rd_data, 8'h55);
    pop_one();
    check("pp_empty", empty, 1);

    // 5: bad parity dropping, storing and counter saturation
    drop_bad = 1'b1;
    for (int i = 0; i < 3; i++) send(8'h39, 1'b0);
    check("drop_count", count, 0);
    check("drop_pec", parity_err_cnt, 3);
    check("drop_overrun", overrun, 0);
    drop_bad = 1'b0;
    send(8'h39, 1'b0);
    check("keep_count", count, 1);
    check("keep_data", rd_data, 8'h39);
    check("keep_pok", rd_parity_ok, 0);
    check("keep_pec", parity_err_cnt, 4);
    pop_one();
    drop_bad = 1'b1;
    for (int i = 0; i < 300; i++) send(8'h39, 1'b0);
    check("sat_pec", parity_err_cnt, 8'hFF);
    check("sat_count", count, 0);

    // 6: clear coincident with increment, then async reset mid-operation
    clr_status = 1'b1;
    send(8'h39, 1'b0);
    clr_status = 1'b0;
    check("clr_inc_pec", parity_err_cnt, 1);
    drop_bad = 1'b0;
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), 1'b1);
    check("pre_rst_count", count, 5);
    reset = 1'b1;
    #1;
    check("async_rst_empty", empty, 1);
    check("async_rst_count", count, 0);
    check("async_rst_data", rd_data, 0);
    check("async_rst_pec", parity_err_cnt, 0);
    reset = 1'b0;
    cycle();
    check("post_rst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
